// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and constants for the unified-memory arbiter.
//   arb_state_t      arbiter state encoding (IDLE / BUSY_I / BUSY_D)
//   PORT_IF, PORT_D  requester identifiers used by the grant selection
//   CNT_W            latency counter width
//   mem_lat_legal()  range check for the memory latency parameter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 15;

    // True when a latency fits the 4-bit counter without wrapping.
    function automatic bit mem_lat_legal(input int unsigned lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Purpose: down-counter that times one memory access.
//   clk, rst    clock, asynchronous active-low clear
//   i_load      load i_load_val (has priority over decrement)
//   i_load_val  value loaded at the grant edge (latency - 1)
//   i_dec       decrement request, saturates at zero
//   o_zero_c    combinational flag: counter is zero
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    // Load on grant, count down while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port fixed-latency memory between the fetch port
// and the data port. Data requests win over fetch; each access holds mem_en for
// MEM_LAT cycles, then pulses the port's ack with registered read data.
//   clk, rst                     clock, asynchronous active-low reset
//   if_req/if_addr               fetch request and address
//   if_rdata/if_ack              fetched word and 1-cycle completion pulse
//   d_rd/d_wr/d_addr/d_wdata     data read/write request, address, write data
//   d_rdata/d_ack                load data and 1-cycle completion pulse
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata          unified memory interface
//   stall                        combinational: a request is still outstanding
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    // An out-of-range latency falls back to the longest the counter can time.
    localparam int unsigned LAT = mem_lat_legal(MEM_LAT) ? MEM_LAT : MEM_LAT_MAX;

    arb_state_t        r_state, w_state_nxt;
    logic              r_mem_en, w_mem_en_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
    logic [DATA_W-1:0] r_d_rdata, w_d_rdata_nxt;
    logic              r_if_ack, w_if_ack_nxt;
    logic              r_d_ack, w_d_ack_nxt;

    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_cnt_zero_c;
    logic w_d_pend;
    logic w_i_pend;
    logic w_sel_port;

    mem_lat_counter #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (CNT_W'(LAT - 1)),
        .i_dec      (w_cnt_dec),
        .o_zero_c   (w_cnt_zero_c)
    );

    // A requester whose ack is high this cycle is masked so its still-high
    // request is not granted a second time.
    assign w_d_pend   = (d_rd | d_wr) & ~r_d_ack;
    assign w_i_pend   = if_req & ~r_if_ack;
    assign w_sel_port = w_d_pend ? PORT_D : PORT_IF;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_if_ack    <= w_if_ack_nxt;
            r_d_ack     <= w_d_ack_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_if_ack_nxt    = 1'b0;
        w_d_ack_nxt     = 1'b0;
        w_cnt_load      = 1'b0;
        w_cnt_dec       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_d_pend || w_i_pend) begin
                    w_cnt_load   = 1'b1;
                    w_mem_en_nxt = 1'b1;
                    if (w_sel_port == PORT_D) begin
                        w_state_nxt     = BUSY_D;
                        w_mem_we_nxt    = d_wr;    // rd & wr together is a write
                        w_mem_addr_nxt  = d_addr;
                        w_mem_wdata_nxt = d_wdata;
                    end else begin
                        w_state_nxt    = BUSY_I;
                        w_mem_we_nxt   = 1'b0;
                        w_mem_addr_nxt = if_addr;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (w_cnt_zero_c) begin
                    w_state_nxt  = IDLE;
                    w_mem_en_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    if (r_state == BUSY_I) begin
                        w_if_ack_nxt   = 1'b1;
                        w_if_rdata_nxt = mem_rdata;
                    end else begin
                        w_d_ack_nxt = 1'b1;
                        if (!r_mem_we) begin
                            w_d_rdata_nxt = mem_rdata;
                        end
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_mem_en_nxt = 1'b0;
                w_mem_we_nxt = 1'b0;
            end
        endcase
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_ack    = r_if_ack;
    assign d_ack     = r_d_ack;

    // Holds the pipeline while any request is still waiting for its ack.
    assign stall = (if_req & ~r_if_ack) | ((d_rd | d_wr) & ~r_d_ack);

endmodule
